gpio_ctrl: RTL and testbench
============================

# gpio_ctrl

Bus-side controller for the 32-bit GPIO output register (`GPIO_reg`). Accepts single-word read/write requests from the core's load/store unit through a req/ack handshake and decodes them against a small register map. Sequences atomic SET/CLEAR/TOGGLE read-modify-write updates onto the register's `in`/`En` port, and returns synchronized pin inputs. Sits between the core data-memory mux and the `GPIO_reg` instance.

## Interface
- `BASE_ADDR`, default 32'h0000_1000: byte base address of the register window; 64-byte aligned.
- `clk`  input  1  system clock; all logic on the rising edge.
- `Rst`  input  1  reset, synchronous, active-high.
- `req`  input  1  access request; held high until `ack`.
- `we`  input  1  1 = write, 0 = read; stable while `req` is high.
- `addr`  input  32  byte address; stable while `req` is high.
- `wdata`  input  32  write data; stable while `req` is high.
- `rdata`  output  32  read data; valid only while `ack`=1.
- `ack`  output  1  one-cycle completion pulse.
- `err`  output  1  error flag; qualified by `ack`.
- `gpio_q`  input  32  current value from the output register's `out`.
- `gpio_d`  output  32  next value to the output register's `in`.
- `gpio_we`  output  1  load enable to the output register's `En`; one-cycle pulse.
- `pins_in`  input  32  asynchronous external input pins.
- `irq`  output  1  edge interrupt; present only with `GPIO_EDGE_IRQ_EN`.

## Operation
- Register map, offset from `BASE_ADDR`:
  - 0x00 OUT: R/W. Write: `gpio_d = wdata`. Read: `gpio_q`.
  - 0x04 SET: WO. `gpio_d = gpio_q | wdata`.
  - 0x08 CLR: WO. `gpio_d = gpio_q & ~wdata`.
  - 0x0C TGL: WO. `gpio_d = gpio_q ^ wdata`.
  - 0x10 IN: RO. Returns `pins_in` after the two-flop synchronizer (`sync2`).
- Reads of SET, CLR or TGL return 0 with `err`=0.
- Error cases: an address outside `BASE_ADDR`..+0x3F, `addr[1:0]`≠0, an unmapped offset, or a write to IN.
  - Response: `ack`=1 and `err`=1.
  - No `gpio_we` pulse and no state change.
  - `rdata`=0.
- FSM states:
  - IDLE: when `req`=1, latch `we`/`addr`/`wdata`, go to EXEC. Otherwise stay.
  - EXEC: decode the access.
    - Valid write: drive `gpio_d`, pulse `gpio_we`.
    - Read: capture the read value into the `rdata` register.
    - Always go to RESP.
  - RESP: `ack`=1, `err` per decode, then go to IDLE unconditionally.
- The requester drops `req` in the cycle `ack` is high. A `req` still high in IDLE after RESP is treated as a new access.
- `gpio_d` holds its last driven value when `gpio_we`=0. It is purely informational when not enabled.

## Timing
- Reset values: `ack`=0, `err`=0, `rdata`=0, `gpio_we`=0, `gpio_d`=0, `irq`=0. The FSM is in IDLE and the synchronizer and IRQ registers are 0.
- Cycle sequence for one access, with `req` sampled high at edge E0:
  - Edge E0: state goes to EXEC.
  - Cycle E0→E1: `gpio_we`=1.
  - Edge E1: `GPIO_reg` loads `gpio_d`; state goes to RESP.
  - Cycle E1→E2: `ack`=1.
  - Edge E2: state goes to IDLE.
- Fixed 2-cycle latency from request sample to `ack`. Throughput is one access per 3 cycles.
- `gpio_q` already reflects the write when `ack` rises.
- SET/CLR/TGL use `gpio_q` sampled in EXEC. A read-modify-write is therefore atomic with respect to this controller, which is the register's sole writer.
- Input latency: a `pins_in` change is visible in IN 2 edges later.
- Reset mid-access (`Rst` high at any edge): the access is dropped. No `ack`, and `gpio_we` is forced to 0 the same edge. A write already loaded at an earlier edge is not undone.

## Configuration
- `GPIO_EDGE_IRQ_EN` defined:
  - Third synchronizer stage `sync3` is added.
  - Register 0x14 IRQ_EN: R/W, reset 0.
  - Register 0x18 IRQ_STAT: R, write-1-to-clear.
  - Rising edge per bit: `sync2 & ~sync3` sets the IRQ_STAT bit.
  - Set and clear of the same bit in the same cycle: set wins.
  - `irq = |(IRQ_STAT & IRQ_EN)`, registered, so it rises one cycle after the status bit.
- `GPIO_EDGE_IRQ_EN` undefined:
  - Offsets 0x14/0x18 are unmapped and return `err`=1.
  - `irq` is tied 0.
  - No `sync3` and no IRQ registers.

## Test plan
- **Reset state:** assert `Rst` 1 cycle → all outputs 0, FSM in IDLE; a `req` raised during `Rst` gets no `ack`.
- **Write/modify sequence:**
  - Write OUT=0x0000_00F0 → `gpio_we` pulses in cycle 1; `ack` in cycle 2; `gpio_q`=0x0000_00F0.
  - SET 0x0F → 0xFF.
  - CLR 0x30 → 0xCF.
  - TGL 0xFFFF_0000 → 0xFFFF_00CF.
- **Input read:** `pins_in`=0xA5A5_5A5A held 3 cycles, then read IN → `rdata`=0xA5A5_5A5A, `err`=0; read SET → `rdata`=0.
- **Errors, no `gpio_we` pulse and `gpio_q` unchanged:**
  - `addr`=BASE_ADDR+0x02 → `ack`+`err`.
  - Write IN → `ack`+`err`.
  - `addr`=BASE_ADDR+0x40 → `ack`+`err`.
- **Reset mid-access:** `Rst` high in EXEC of an OUT write → no `ack` follows.
- **Edge IRQ (`GPIO_EDGE_IRQ_EN` defined):**
  - IRQ_EN=0x1, `pins_in[0]` 0→1 → IRQ_STAT=0x1; `irq`=1.
  - Write 0x1 to IRQ_STAT → `irq`=0.
  - New rising edge on the same cycle as the W1C → bit stays set.

Source files
------------

// File: rtl/gpio_ctrl_if.sv
// gpio_ctrl_if: single-word request/acknowledge bus between the core
// load/store unit (master) and the GPIO controller (slave).
interface gpio_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err
  );
endinterface

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: bus-side controller for the 32-bit GPIO output register.
// Decodes OUT/SET/CLR/TGL/IN accesses, sequences atomic read-modify-write
// updates onto the register's in/En port, and returns synchronized pins.
// Optional feature macro: GPIO_EDGE_IRQ_EN adds per-bit rising-edge
// interrupt status (IRQ_EN at 0x14, IRQ_STAT W1C at 0x18) and the irq output.
module gpio_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DATA_W    = 32
) (
  input  logic              clk,
  input  logic              Rst,
  gpio_ctrl_if.slave        bus,
  input  logic [DATA_W-1:0] gpio_q,
  output logic [DATA_W-1:0] gpio_d,
  output logic              gpio_we,
  input  logic [DATA_W-1:0] pins_in,
  output logic              irq
);

  localparam logic [5:0] OFF_OUT  = 6'h00;
  localparam logic [5:0] OFF_SET  = 6'h04;
  localparam logic [5:0] OFF_CLR  = 6'h08;
  localparam logic [5:0] OFF_TGL  = 6'h0C;
  localparam logic [5:0] OFF_IN   = 6'h10;
  localparam logic [5:0] OFF_IREN = 6'h14;
  localparam logic [5:0] OFF_IRST = 6'h18;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state, state_nxt;
  logic              we_r;
  logic [31:0]       addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] sync1, sync2;
  logic [DATA_W-1:0] gpio_d_hold;
  logic [DATA_W-1:0] new_d;
  logic [DATA_W-1:0] rd_val;
  logic              gpio_wr;
  logic              dec_err;
  logic              en_sel;
  logic              stat_sel;
  logic              in_win;
  logic [5:0]        off;

`ifdef GPIO_EDGE_IRQ_EN
  logic [DATA_W-1:0] sync3, irq_en, irq_stat;
  logic              irq_q;
`endif

  assign in_win = (addr_r[31:6] == BASE_ADDR[31:6]);
  assign off    = addr_r[5:0];

  // FSM state register; reset drops any access in flight
  always_ff @(posedge clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: fixed IDLE -> EXEC -> RESP sequence
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture; bus fields are only consumed in EXEC so no reset needed
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req) begin
      we_r    <= bus.we;
      addr_r  <= bus.addr;
      wdata_r <= bus.wdata;
    end
  end

  // Two-flop synchronizer for the asynchronous input pins
  always_ff @(posedge clk) begin
    if (Rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pins_in;
      sync2 <= sync1;
    end
  end

  // Address decode of the latched access; gpio_q read here makes RMW atomic
  always_comb begin
    new_d    = gpio_q;
    rd_val   = '0;
    gpio_wr  = 1'b0;
    dec_err  = 1'b0;
    en_sel   = 1'b0;
    stat_sel = 1'b0;
    if (!in_win || addr_r[1:0] != 2'b00) begin
      dec_err = 1'b1;
    end else begin
      case (off)
        OFF_OUT: begin
          if (we_r) begin
            new_d   = wdata_r;
            gpio_wr = 1'b1;
          end else begin
            rd_val = gpio_q;
          end
        end
        OFF_SET: if (we_r) begin new_d = gpio_q | wdata_r;  gpio_wr = 1'b1; end
        OFF_CLR: if (we_r) begin new_d = gpio_q & ~wdata_r; gpio_wr = 1'b1; end
        OFF_TGL: if (we_r) begin new_d = gpio_q ^ wdata_r;  gpio_wr = 1'b1; end
        OFF_IN: begin
          if (we_r) dec_err = 1'b1;
          else      rd_val  = sync2;
        end
`ifdef GPIO_EDGE_IRQ_EN
        OFF_IREN: begin
          if (we_r) en_sel = 1'b1;
          else      rd_val = irq_en;
        end
        OFF_IRST: begin
          if (we_r) stat_sel = 1'b1;
          else      rd_val   = irq_stat;
        end
`else
        OFF_IREN, OFF_IRST: dec_err = 1'b1;
`endif
        default: dec_err = 1'b1;
      endcase
    end
  end

  // Load enable is suppressed by reset in the same cycle so a dropped access never loads
  assign gpio_we = (state == EXEC) && gpio_wr && !Rst;
  assign gpio_d  = gpio_we ? new_d : gpio_d_hold;

  // Hold the last driven gpio_d between writes
  always_ff @(posedge clk) begin
    if (Rst) gpio_d_hold <= '0;
    else     gpio_d_hold <= gpio_d;
  end

  // Response registers: presented during RESP
  always_ff @(posedge clk) begin
    if (Rst) begin
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ack   <= (state == EXEC);
      bus.err   <= (state == EXEC) && dec_err;
      bus.rdata <= (state == EXEC) ? rd_val : '0;
    end
  end

`ifdef GPIO_EDGE_IRQ_EN
  // Edge detect, enable/status registers and registered interrupt; a new edge beats W1C
  always_ff @(posedge clk) begin
    if (Rst) begin
      sync3    <= '0;
      irq_en   <= '0;
      irq_stat <= '0;
      irq_q    <= 1'b0;
    end else begin
      sync3 <= sync2;
      if (state == EXEC && en_sel) irq_en <= wdata_r;
      irq_stat <= (irq_stat & ~((state == EXEC && stat_sel) ? wdata_r : '0))
                | (sync2 & ~sync3);
      irq_q <= |(irq_stat & irq_en);
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed self-checking bench for gpio_ctrl with a simple
// model of the downstream GPIO output register.
module tb_gpio_ctrl;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        Rst;
  logic [31:0] gpio_q = '0;
  logic [31:0] gpio_d;
  logic        gpio_we;
  logic [31:0] pins_in;
  logic        irq;

  int total = 0;
  int bad   = 0;

  gpio_ctrl_if #(.DATA_W(32)) bus ();

  gpio_ctrl #(.BASE_ADDR(BASE), .DATA_W(32)) dut (
    .clk     (clk),
    .Rst     (Rst),
    .bus     (bus.slave),
    .gpio_q  (gpio_q),
    .gpio_d  (gpio_d),
    .gpio_we (gpio_we),
    .pins_in (pins_in),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream output register
  always @(posedge clk) if (gpio_we) gpio_q <= gpio_d;

  // One bus access; reports the cycle (after the request sample) of the
  // first gpio_we and of ack, plus the number of gpio_we cycles seen.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er,
                        output int we_cyc, output int ack_cyc, output int we_cnt,
                        output logic [31:0] q_at_ack);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;
    we_cyc = 0; ack_cyc = 0; we_cnt = 0; rd = '0; er = 1'b0; q_at_ack = '0;
    for (int c = 1; c <= 10 && ack_cyc == 0; c++) begin
      @(posedge clk); #1;
      if (gpio_we) begin
        we_cnt++;
        if (we_cyc == 0) we_cyc = c;
      end
      if (bus.ack) begin
        ack_cyc  = c;
        rd       = bus.rdata;
        er       = bus.err;
        q_at_ack = gpio_q;
        bus.req  = 1'b0;
      end
    end
    bus.req = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    int ack_seen;
    ack_seen = 0;
    Rst = 1'b1;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = BASE; bus.wdata = 32'hDEAD_BEEF;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.ack || gpio_we) ack_seen++;
    end
    @(negedge clk);
    Rst = 1'b0; bus.req = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.ack || gpio_we) ack_seen++;
    end
    total++; if (ack_seen !== 0) begin bad++; $display("FAIL rst_no_ack: got %0d want 0", ack_seen); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.err); end
    total++; if (bus.rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
    total++; if (gpio_d !== 32'h0) begin bad++; $display("FAIL rst_gpio_d: got %h want 0", gpio_d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    total++; if (gpio_q !== 32'h0) begin bad++; $display("FAIL rst_gpio_q: got %h want 0", gpio_q); end
  endtask

  task automatic test_write_modify();
    logic [31:0] rd, q; logic er; int wc, ac, wn;
    access(1'b1, BASE + 32'h00, 32'h0000_00F0, rd, er, wc, ac, wn, q);
    total++; if (wc !== 1) begin bad++; $display("FAIL out_we_cycle: got %0d want 1", wc); end
    total++; if (ac !== 2) begin bad++; $display("FAIL out_ack_cycle: got %0d want 2", ac); end
    total++; if (wn !== 1) begin bad++; $display("FAIL out_we_count: got %0d want 1", wn); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL out_err: got %b want 0", er); end
    total++; if (q !== 32'h0000_00F0) begin bad++; $display("FAIL out_q: got %h want 000000f0", q); end
    access(1'b1, BASE + 32'h04, 32'h0000_000F, rd, er, wc, ac, wn, q);
    total++; if (q !== 32'h0000_00FF) begin bad++; $display("FAIL set_q: got %h want 000000ff", q); end
    total++; if (wn !== 1 || er !== 1'b0) begin bad++; $display("FAIL set_we_err: got we=%0d err=%b want 1/0", wn, er); end
    access(1'b1, BASE + 32'h08, 32'h0000_0030, rd, er, wc, ac, wn, q);
    total++; if (q !== 32'h0000_00CF) begin bad++; $display("FAIL clr_q: got %h want 000000cf", q); end
    access(1'b1, BASE + 32'h0C, 32'hFFFF_0000, rd, er, wc, ac, wn, q);
    total++; if (q !== 32'hFFFF_00CF) begin bad++; $display("FAIL tgl_q: got %h want ffff00cf", q); end
    access(1'b0, BASE + 32'h00, 32'h0, rd, er, wc, ac, wn, q);
    total++; if (rd !== 32'hFFFF_00CF) begin bad++; $display("FAIL out_read: got %h want ffff00cf", rd); end
    total++; if (wn !== 0) begin bad++; $display("FAIL out_read_we: got %0d want 0", wn); end
  endtask

  task automatic test_input_read();
    logic [31:0] rd, q; logic er; int wc, ac, wn;
    @(negedge clk);
    pins_in = 32'hA5A5_5A5A;
    repeat (3) @(posedge clk);
    access(1'b0, BASE + 32'h10, 32'h0, rd, er, wc, ac, wn, q);
    total++; if (rd !== 32'hA5A5_5A5A) begin bad++; $display("FAIL in_read: got %h want a5a55a5a", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL in_err: got %b want 0", er); end
    access(1'b0, BASE + 32'h04, 32'h0, rd, er, wc, ac, wn, q);
    total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL set_read: got %h/%b want 0/0", rd, er); end
  endtask

  task automatic test_errors();
    logic [31:0] rd, q; logic er; int wc, ac, wn;
    access(1'b1, BASE + 32'h02, 32'hFFFF_FFFF, rd, er, wc, ac, wn, q);
    total++; if (ac !== 2 || er !== 1'b1) begin bad++; $display("FAIL misalign_resp: got ack_cyc=%0d err=%b want 2/1", ac, er); end
    total++; if (wn !== 0 || q !== 32'hFFFF_00CF) begin bad++; $display("FAIL misalign_state: got we=%0d q=%h want 0/ffff00cf", wn, q); end
    access(1'b1, BASE + 32'h10, 32'h0000_0000, rd, er, wc, ac, wn, q);
    total++; if (er !== 1'b1 || wn !== 0) begin bad++; $display("FAIL wr_in: got err=%b we=%0d want 1/0", er, wn); end
    total++; if (q !== 32'hFFFF_00CF) begin bad++; $display("FAIL wr_in_q: got %h want ffff00cf", q); end
    access(1'b0, BASE + 32'h40, 32'h0, rd, er, wc, ac, wn, q);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL out_window: got err=%b rdata=%h want 1/0", er, rd); end
    access(1'b1, BASE + 32'h40, 32'h1234_5678, rd, er, wc, ac, wn, q);
    total++; if (er !== 1'b1 || wn !== 0 || q !== 32'hFFFF_00CF) begin bad++; $display("FAIL out_window_wr: got err=%b we=%0d q=%h", er, wn, q); end
    access(1'b0, BASE + 32'h1C, 32'h0, rd, er, wc, ac, wn, q);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL unmapped_1c: got %b want 1", er); end
`ifndef GPIO_EDGE_IRQ_EN
    access(1'b1, BASE + 32'h14, 32'h1, rd, er, wc, ac, wn, q);
    total++; if (er !== 1'b1 || wn !== 0) begin bad++; $display("FAIL unmapped_14: got err=%b we=%0d want 1/0", er, wn); end
    access(1'b0, BASE + 32'h18, 32'h0, rd, er, wc, ac, wn, q);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL unmapped_18: got err=%b rdata=%h want 1/0", er, rd); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, q; logic er; int wc, ac, wn;
    access(1'b1, BASE + 32'h04, 32'h0000_0100, rd, er, wc, ac, wn, q);
    total++; if (q !== 32'hFFFF_01CF || ac !== 2) begin bad++; $display("FAIL b2b_set: got q=%h ack_cyc=%0d want ffff01cf/2", q, ac); end
    access(1'b1, BASE + 32'h08, 32'hFFFF_0000, rd, er, wc, ac, wn, q);
    total++; if (q !== 32'h0000_01CF || wc !== 1) begin bad++; $display("FAIL b2b_clr: got q=%h we_cyc=%0d want 000001cf/1", q, wc); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, q; logic er; int wc, ac, wn, ack_seen;
    ack_seen = 0;
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = BASE; bus.wdata = 32'h1234_5678;
    @(posedge clk); #1;
    Rst = 1'b1;
    #1;
    total++; if (gpio_we !== 1'b0) begin bad++; $display("FAIL mid_rst_we: got %b want 0", gpio_we); end
    @(negedge clk);
    bus.req = 1'b0;
    @(posedge clk); #1;
    if (bus.ack) ack_seen++;
    Rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.ack || gpio_we) ack_seen++;
    end
    total++; if (ack_seen !== 0) begin bad++; $display("FAIL mid_rst_ack: got %0d want 0", ack_seen); end
    total++; if (gpio_q !== 32'h0000_01CF) begin bad++; $display("FAIL mid_rst_q: got %h want 000001cf", gpio_q); end
    access(1'b0, BASE, 32'h0, rd, er, wc, ac, wn, q);
    total++; if (rd !== 32'h0000_01CF || ac !== 2) begin bad++; $display("FAIL mid_rst_recover: got %h ack_cyc=%0d want 000001cf/2", rd, ac); end
  endtask

`ifdef GPIO_EDGE_IRQ_EN
  task automatic test_irq();
    logic [31:0] rd, q; logic er; int wc, ac, wn;
    access(1'b1, BASE + 32'h18, 32'hFFFF_FFFF, rd, er, wc, ac, wn, q);
    access(1'b1, BASE + 32'h14, 32'h0000_0001, rd, er, wc, ac, wn, q);
    total++; if (er !== 1'b0 || wn !== 0) begin bad++; $display("FAIL irq_en_wr: got err=%b we=%0d want 0/0", er, wn); end
    access(1'b0, BASE + 32'h18, 32'h0, rd, er, wc, ac, wn, q);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL irq_stat_clear: got %h want 0", rd); end
    @(negedge clk);
    pins_in[0] = 1'b1;
    repeat (5) @(posedge clk);
    access(1'b0, BASE + 32'h18, 32'h0, rd, er, wc, ac, wn, q);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL irq_stat_set: got %h want 1", rd); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_high: got %b want 1", irq); end
    access(1'b1, BASE + 32'h18, 32'h1, rd, er, wc, ac, wn, q);
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c: got %b want 0", irq); end
    @(negedge clk);
    pins_in[0] = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    pins_in[0] = 1'b1;
    access(1'b1, BASE + 32'h18, 32'h1, rd, er, wc, ac, wn, q);
    access(1'b0, BASE + 32'h18, 32'h0, rd, er, wc, ac, wn, q);
    total++; if (rd !== 32'h1) begin bad++; $display("FAIL irq_set_wins: got %h want 1", rd); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set_wins_irq: got %b want 1", irq); end
  endtask
`endif

  initial begin
    Rst = 1'b1;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    pins_in = '0;
    test_reset();
    test_write_modify();
    test_input_read();
    test_errors();
    test_back_to_back();
    test_reset_mid();
`ifdef GPIO_EDGE_IRQ_EN
    test_irq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
